pht_port_scheduler: RTL and testbench

PHT_PORT_SCHEDULER -- requirements
Module: pht_port_scheduler

---
 rtl/bp_pkg.sv | 17 +
 rtl/bp_update_fifo.sv | 64 ++++++
 rtl/pht_port_scheduler.sv | 125 ++++++++++++
 tb/tb_pht_port_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare PHT port scheduler.
package bp_pkg;

  localparam int GHR_SIZE    = 8;
  localparam int QUEUE_DEPTH = 4;

  localparam logic [1:0] WEAK_TAKEN = 2'b10;

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPD_WR = 2'd2
  } state_e;

endpackage

// File: rtl/bp_update_fifo.sv
// Update queue for resolved-branch counter updates; power-of-2 depth, wrapping pointers.
module bp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge i_Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/pht_port_scheduler.sv
// Arbitrates the single-port PHT RAM between fetch lookups, queued counter
// updates (read-modify-write) and the post-reset weakly-taken fill.
module pht_port_scheduler #(
  parameter int GHR_SIZE    = bp_pkg::GHR_SIZE,
  parameter int QUEUE_DEPTH = bp_pkg::QUEUE_DEPTH
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset_n,
  input  logic                         i_lookup_req,
  input  logic [GHR_SIZE-1:0]          i_lookup_index,
  output logic                         o_lookup_grant,
  output logic                         o_lookup_valid,
  output logic                         o_lookup_taken,
  input  logic                         i_upd_valid,
  input  logic [GHR_SIZE-1:0]          i_upd_index,
  input  logic                         i_upd_outcome,
  output logic                         o_upd_ready,
  output logic                         o_pht_en,
  output logic                         o_pht_we,
  output logic [GHR_SIZE-1:0]          o_pht_addr,
  output logic [1:0]                   o_pht_wdata,
  input  logic [1:0]                   i_pht_rdata,
  output logic                         o_busy,
  output logic [$clog2(QUEUE_DEPTH):0] o_queue_count
);

  import bp_pkg::*;

  localparam int ENTRY_W = GHR_SIZE + 1;

  state_e              state_q, state_d;
  logic [GHR_SIZE-1:0] init_addr_q, init_addr_d;
  logic                lookup_valid_q;
  logic                q_full, q_empty, q_pop;
  logic [ENTRY_W-1:0]  q_head;
  logic [GHR_SIZE-1:0] head_index;
  logic                head_taken;

  function automatic ctr_t sat_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    if (taken) nxt = (cur == 2'b11) ? cur : cur + 2'b01;
    else       nxt = (cur == 2'b00) ? cur : cur - 2'b01;
    return nxt;
  endfunction

  assign head_index = q_head[GHR_SIZE-1:0];
  assign head_taken = q_head[GHR_SIZE];

  bp_update_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_push    (i_upd_valid & o_upd_ready),
    .i_wdata   ({i_upd_outcome, i_upd_index}),
    .i_pop     (q_pop),
    .o_head    (q_head),
    .o_full    (q_full),
    .o_empty   (q_empty),
    .o_count   (o_queue_count)
  );

  always_comb begin
    state_d        = state_q;
    init_addr_d    = init_addr_q;
    o_lookup_grant = 1'b0;
    o_pht_en       = 1'b0;
    o_pht_we       = 1'b0;
    o_pht_addr     = '0;
    o_pht_wdata    = 2'b00;
    q_pop          = 1'b0;
    case (state_q)
      INIT: begin
        // Gated by reset so the RAM sees no write while reset is held.
        if (i_Reset_n) begin
          o_pht_en    = 1'b1;
          o_pht_we    = 1'b1;
          o_pht_addr  = init_addr_q;
          o_pht_wdata = WEAK_TAKEN;
        end
        init_addr_d = init_addr_q + GHR_SIZE'(1);
        if (init_addr_q == {GHR_SIZE{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (i_lookup_req && !q_full) begin
          o_lookup_grant = 1'b1;
          o_pht_en       = 1'b1;
          o_pht_addr     = i_lookup_index;
        end else if (!q_empty) begin
          o_pht_en   = 1'b1;
          o_pht_addr = head_index;
          state_d    = UPD_WR;
        end
      end
      UPD_WR: begin
        o_pht_en    = 1'b1;
        o_pht_we    = 1'b1;
        o_pht_addr  = head_index;
        o_pht_wdata = sat_next(i_pht_rdata, head_taken);
        q_pop       = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q        <= INIT;
      init_addr_q    <= '0;
      lookup_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_addr_q    <= init_addr_d;
      lookup_valid_q <= o_lookup_grant;
    end
  end

  assign o_lookup_valid = lookup_valid_q;
  assign o_lookup_taken = lookup_valid_q & i_pht_rdata[1];
  assign o_upd_ready    = (state_q != INIT) & ~q_full;
  assign o_busy         = (state_q == INIT) | ~q_empty;

endmodule

// File: tb/tb_pht_port_scheduler.sv
// Directed bench for pht_port_scheduler with a behavioural single-port PHT RAM.
module tb_pht_port_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lookup_req;
  logic [7:0] lookup_index;
  logic       lookup_grant, lookup_valid, lookup_taken;
  logic       upd_valid;
  logic [7:0] upd_index;
  logic       upd_outcome;
  logic       upd_ready;
  logic       pht_en, pht_we;
  logic [7:0] pht_addr;
  logic [1:0] pht_wdata;
  logic [1:0] pht_rdata;
  logic       busy;
  logic [2:0] queue_count;
  logic       seed;

  logic [1:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pht_port_scheduler #(.GHR_SIZE(8), .QUEUE_DEPTH(4)) dut (
    .i_Clk          (clk),
    .i_Reset_n      (rst_n),
    .i_lookup_req   (lookup_req),
    .i_lookup_index (lookup_index),
    .o_lookup_grant (lookup_grant),
    .o_lookup_valid (lookup_valid),
    .o_lookup_taken (lookup_taken),
    .i_upd_valid    (upd_valid),
    .i_upd_index    (upd_index),
    .i_upd_outcome  (upd_outcome),
    .o_upd_ready    (upd_ready),
    .o_pht_en       (pht_en),
    .o_pht_we       (pht_we),
    .o_pht_addr     (pht_addr),
    .o_pht_wdata    (pht_wdata),
    .i_pht_rdata    (pht_rdata),
    .o_busy         (busy),
    .o_queue_count  (queue_count)
  );

  // RAM seeded to weakly-not-taken so a taken prediction proves the fill happened.
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem[i] <= 2'b01;
    end else if (pht_en) begin
      if (pht_we) mem[pht_addr] <= pht_wdata;
      else        pht_rdata     <= mem[pht_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pht(input string tag, input logic en, input logic we, input logic [7:0] addr);
    chk({tag, "_en"}, pht_en, en);
    chk({tag, "_we"}, pht_we, we);
    if (en) chk({tag, "_addr"}, pht_addr, addr);
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pht(tag, 1'b1, 1'b1, i[7:0]);
      chk({tag, "_wdata"}, pht_wdata, 2'b10);
      chk({tag, "_grant"}, lookup_grant, 1'b0);
      chk({tag, "_ready"}, upd_ready, 1'b0);
      step();
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_grant"}, lookup_grant, 1'b0);
    chk({tag, "_valid"}, lookup_valid, 1'b0);
    chk({tag, "_taken"}, lookup_taken, 1'b0);
    chk({tag, "_ready"}, upd_ready, 1'b0);
    chk({tag, "_en"}, pht_en, 1'b0);
    chk({tag, "_we"}, pht_we, 1'b0);
    chk({tag, "_addr"}, pht_addr, 8'h00);
    chk({tag, "_wdata"}, pht_wdata, 2'b00);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_count"}, queue_count, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0; seed = 1'b1;
    lookup_req = 1'b1; lookup_index = 8'h3C;
    upd_valid = 1'b0; upd_index = 8'h00; upd_outcome = 1'b0;
    repeat (3) @(posedge clk);
    #1 seed = 1'b0;
    @(negedge clk);
    reset_outputs("rst");
    step();

    // Fill: 256 writes of weakly-taken while the held lookup is refused.
    rst_n = 1'b1;
    run_init("init");

    // Cycle 257: first grant; cycle 258: prediction from the filled RAM.
    @(negedge clk);
    chk("g257_grant", lookup_grant, 1'b1);
    pht("g257", 1'b1, 1'b0, 8'h3C);
    chk("g257_ready", upd_ready, 1'b1);
    chk("g257_busy", busy, 1'b0);
    step();
    @(negedge clk);
    chk("v258_valid", lookup_valid, 1'b1);
    chk("v258_taken", lookup_taken, 1'b1);
    step();

    // Taken update to 0x3C: read then write of 2'b11.
    lookup_req = 1'b0; upd_valid = 1'b1; upd_index = 8'h3C; upd_outcome = 1'b1;
    @(negedge clk);
    chk("push3c_ready", upd_ready, 1'b1);
    pht("push3c_idle", 1'b0, 1'b0, 8'h00);
    step();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("rd3c_count", queue_count, 3'd1);
    chk("rd3c_busy", busy, 1'b1);
    pht("rd3c", 1'b1, 1'b0, 8'h3C);
    step();
    @(negedge clk);
    pht("wr3c", 1'b1, 1'b1, 8'h3C);
    chk("wr3c_wdata", pht_wdata, 2'b11);
    chk("wr3c_grant", lookup_grant, 1'b0);
    step();
    lookup_req = 1'b1; lookup_index = 8'h3C;
    @(negedge clk);
    chk("lk3c_grant", lookup_grant, 1'b1);
    chk("lk3c_count", queue_count, 3'd0);
    step();

    // Fill the queue with not-taken updates to 0x05 while lookups stream.
    lookup_index = 8'h05; upd_valid = 1'b1; upd_index = 8'h05; upd_outcome = 1'b0;
    @(negedge clk);
    chk("lk3c_taken", lookup_taken, 1'b1);
    chk("A_grant", lookup_grant, 1'b1);
    chk("A_count", queue_count, 3'd0);
    step();
    @(negedge clk); chk("B_count", queue_count, 3'd1); chk("B_grant", lookup_grant, 1'b1); step();
    @(negedge clk); chk("C_count", queue_count, 3'd2); chk("C_grant", lookup_grant, 1'b1); step();
    @(negedge clk);
    chk("D_count", queue_count, 3'd3);
    chk("D_ready", upd_ready, 1'b1);
    chk("D_taken", lookup_taken, 1'b1);
    step();
    @(negedge clk);
    chk("E_count", queue_count, 3'd4);
    chk("E_grant", lookup_grant, 1'b0);
    chk("E_ready", upd_ready, 1'b0);
    pht("E", 1'b1, 1'b0, 8'h05);
    step();
    @(negedge clk);
    chk("F_count", queue_count, 3'd4);
    chk("F_ready", upd_ready, 1'b0);
    chk("F_grant", lookup_grant, 1'b0);
    pht("F", 1'b1, 1'b1, 8'h05);
    chk("F_wdata", pht_wdata, 2'b01);
    step();
    @(negedge clk);
    chk("G_count", queue_count, 3'd3);
    chk("G_ready", upd_ready, 1'b1);
    chk("G_grant", lookup_grant, 1'b1);
    step();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("H_count", queue_count, 3'd4);
    chk("H_grant", lookup_grant, 1'b0);
    chk("H_valid", lookup_valid, 1'b1);
    chk("H_taken", lookup_taken, 1'b0);
    step();
    @(negedge clk);
    pht("I", 1'b1, 1'b1, 8'h05);
    chk("I_wdata", pht_wdata, 2'b00);
    step();
    @(negedge clk); chk("J_count", queue_count, 3'd3); chk("J_grant", lookup_grant, 1'b1); step();
    lookup_req = 1'b0;
    @(negedge clk);
    chk("K_valid", lookup_valid, 1'b1);
    chk("K_taken", lookup_taken, 1'b0);
    pht("K", 1'b1, 1'b0, 8'h05);
    step();
    @(negedge clk);
    chk("L_wdata_sat", pht_wdata, 2'b00);
    pht("L", 1'b1, 1'b1, 8'h05);
    step();
    step(); step(); step(); step();
    @(negedge clk);
    chk("Q_count", queue_count, 3'd0);
    chk("Q_busy", busy, 1'b0);
    pht("Q_idle", 1'b0, 1'b0, 8'h00);
    step();

    // Three taken updates queued, reset asserted during the first write-back.
    lookup_req = 1'b1; lookup_index = 8'h00;
    upd_valid = 1'b1; upd_outcome = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_index = 8'h10 + i[7:0];
      @(negedge clk);
      chk("R_push_ready", upd_ready, 1'b1);
      step();
    end
    lookup_req = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    chk("R4_count", queue_count, 3'd3);
    pht("R4", 1'b1, 1'b0, 8'h10);
    step();
    @(negedge clk);
    pht("R5", 1'b1, 1'b1, 8'h10);
    chk("R5_wdata", pht_wdata, 2'b11);
    #1 rst_n = 1'b0;
    #1 reset_outputs("midrst");
    step();
    step();
    rst_n = 1'b1;
    chk("midrst_nowrite", mem[8'h10], 2'b10);
    run_init("reinit");
    @(negedge clk);
    chk("post_busy", busy, 1'b0);
    chk("post_count", queue_count, 3'd0);
    chk("post_3c", mem[8'h3C], 2'b10);
    chk("post_10", mem[8'h10], 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
